// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// saturating shift counter. Optional rotate support via UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     mode,
  input  logic [WIDTH-1:0]               D,
  input  logic                           SIR,
  input  logic                           SIL,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic                           rot,
`endif
  output logic [WIDTH-1:0]               Q,
  output logic [WIDTH-1:0]               Qn,
  output logic                           SO,
  output logic [$clog2(WIDTH+1)-1:0]     cnt,
  output logic                           done
);

  localparam int CW = $clog2(WIDTH+1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             right_in;
  logic             left_in;

  // Bits entering at each end: serial inputs, or the wrapped-around bit when rotating.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign right_in = rot ? q_reg[0]       : SIR;
  assign left_in  = rot ? q_reg[WIDTH-1] : SIL;
`else
  assign right_in = SIR;
  assign left_in  = SIL;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic from_upper;
      logic from_lower;

      if (gi == WIDTH-1) begin : g_msb
        assign from_upper = right_in;
      end else begin : g_mid_hi
        assign from_upper = q_reg[gi+1];
      end

      if (gi == 0) begin : g_lsb
        assign from_lower = left_in;
      end else begin : g_mid_lo
        assign from_lower = q_reg[gi-1];
      end

      always_comb begin
        q_next[gi] = q_reg[gi];
        case (mode)
          MODE_HOLD:  q_next[gi] = q_reg[gi];
          MODE_RIGHT: q_next[gi] = from_upper;
          MODE_LEFT:  q_next[gi] = from_lower;
          MODE_LOAD:  q_next[gi] = D[gi];
          default:    q_next[gi] = q_reg[gi];
        endcase
      end
    end
  endgenerate

  // Every shift or rotate counts toward a full word, regardless of direction.
  always_comb begin
    cnt_next = cnt_reg;
    case (mode)
      MODE_HOLD:  cnt_next = cnt_reg;
      MODE_RIGHT,
      MODE_LEFT:  cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
      MODE_LOAD:  cnt_next = '0;
      default:    cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= RESET_VALUE;
      cnt_reg <= '0;
    end else begin
      q_reg   <= q_next;
      cnt_reg <= cnt_next;
    end
  end

  assign Q    = q_reg;
  assign Qn   = ~q_reg;
  assign SO   = (mode == MODE_RIGHT) ? q_reg[0] : q_reg[WIDTH-1];
  assign cnt  = cnt_reg;
  assign done = (cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VALUE=A5); rotate scenario
// runs only when UNIV_SHIFT_REG_ROTATE_EN is defined.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] RV = 8'hA5;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             SIR;
  logic             SIL;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             SO;
  logic [3:0]       cnt;
  logic             done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .D   (D),
    .SIR (SIR),
    .SIL (SIL),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot (rot),
`endif
    .Q   (Q),
    .Qn  (Qn),
    .SO  (SO),
    .cnt (cnt),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 2'b11; D = 8'h00; SIR = 1'b0; SIL = 1'b0;
    step();
    checks++;
    if (Q !== 8'h00) begin errors++; $display("FAIL reset_preload Q got %h expected %h", Q, 8'h00); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Q !== 8'hA5) begin errors++; $display("FAIL reset_async Q got %h expected %h", Q, 8'hA5); end
    checks++;
    if (Qn !== 8'h5A) begin errors++; $display("FAIL reset_async Qn got %h expected %h", Qn, 8'h5A); end
    checks++;
    if (cnt !== 4'd0) begin errors++; $display("FAIL reset_async cnt got %0d expected 0", cnt); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_async done got %b expected 0", done); end
    mode = 2'b00;
    #1 rst = 1'b0;
    step();
    checks++;
    if (Q !== 8'hA5) begin errors++; $display("FAIL reset_release_hold Q got %h expected %h", Q, 8'hA5); end
    $display("test_reset: Q=%h Qn=%h cnt=%0d done=%b", Q, Qn, cnt, done);
  endtask

  task automatic test_shift_right();
    logic [7:0] so_exp;
    so_exp = 8'b1001_0110;
    mode = 2'b11; D = 8'b1001_0110;
    step();
    checks++;
    if (Q !== 8'h96 || cnt !== 4'd0) begin errors++; $display("FAIL sr_load Q/cnt got %h/%0d expected 96/0", Q, cnt); end
    for (int i = 0; i < 8; i++) begin
      mode = 2'b01; SIR = 1'b1;
      #1;
      checks++;
      if (SO !== so_exp[i]) begin errors++; $display("FAIL sr_so[%0d] got %b expected %b", i, SO, so_exp[i]); end
      step();
      checks++;
      if (cnt !== 4'(i + 1)) begin errors++; $display("FAIL sr_cnt[%0d] got %0d expected %0d", i, cnt, i + 1); end
      checks++;
      if (done !== (i == 7)) begin errors++; $display("FAIL sr_done[%0d] got %b expected %b", i, done, (i == 7)); end
      $display("test_shift_right: edge %0d Q=%h cnt=%0d done=%b", i + 1, Q, cnt, done);
    end
    checks++;
    if (Q !== 8'hFF) begin errors++; $display("FAIL sr_final Q got %h expected ff", Q); end
  endtask

  task automatic test_shift_left_sat();
    logic [15:0] wide;
    logic [7:0]  q_exp;
    mode = 2'b11; D = 8'h81;
    step();
    for (int k = 1; k <= 10; k++) begin
      mode = 2'b10; SIL = 1'b0;
      #1;
      wide  = 16'h0081 << (k - 1);
      q_exp = wide[7:0];
      checks++;
      if (SO !== q_exp[7]) begin errors++; $display("FAIL sl_so[%0d] got %b expected %b", k, SO, q_exp[7]); end
      step();
      wide  = 16'h0081 << k;
      q_exp = wide[7:0];
      checks++;
      if (Q !== q_exp) begin errors++; $display("FAIL sl_q[%0d] got %h expected %h", k, Q, q_exp); end
      checks++;
      if (cnt !== ((k >= 8) ? 4'd8 : 4'(k))) begin errors++; $display("FAIL sl_cnt[%0d] got %0d expected %0d", k, cnt, (k >= 8) ? 8 : k); end
      checks++;
      if (done !== (k >= 8)) begin errors++; $display("FAIL sl_done[%0d] got %b expected %b", k, done, (k >= 8)); end
      $display("test_shift_left_sat: edge %0d Q=%h cnt=%0d done=%b", k, Q, cnt, done);
    end
  endtask

  task automatic test_hold_reload();
    for (int i = 0; i < 3; i++) begin
      mode = 2'b00; SIL = 1'b1; SIR = 1'b1; D = 8'hFF;
      step();
      checks++;
      if (Q !== 8'h00 || cnt !== 4'd8 || done !== 1'b1) begin
        errors++; $display("FAIL hold[%0d] Q/cnt/done got %h/%0d/%b expected 00/8/1", i, Q, cnt, done);
      end
      $display("test_hold_reload: hold %0d Q=%h cnt=%0d done=%b", i, Q, cnt, done);
    end
    mode = 2'b11; D = 8'h3C;
    step();
    checks++;
    if (Q !== 8'h3C || Qn !== 8'hC3) begin errors++; $display("FAIL reload Q/Qn got %h/%h expected 3c/c3", Q, Qn); end
    checks++;
    if (cnt !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL reload cnt/done got %0d/%b expected 0/0", cnt, done); end
    mode = 2'b00;
    #1;
    checks++;
    if (SO !== 1'b0) begin errors++; $display("FAIL hold_so got %b expected 0", SO); end
    $display("test_hold_reload: reload Q=%h Qn=%h cnt=%0d done=%b", Q, Qn, cnt, done);
  endtask

  task automatic test_reset_mid();
    mode = 2'b11; D = 8'hC3;
    step();
    for (int i = 0; i < 4; i++) begin
      mode = 2'b01; SIR = 1'b0;
      step();
    end
    checks++;
    if (Q !== 8'h0C || cnt !== 4'd4) begin errors++; $display("FAIL mid_pre Q/cnt got %h/%0d expected 0c/4", Q, cnt); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset Q/cnt/done got %h/%0d/%b expected a5/0/0", Q, cnt, done);
    end
    SIR = 1'b1;
    #1 rst = 1'b0;
    step();
    checks++;
    if (Q !== 8'hD2 || cnt !== 4'd1) begin errors++; $display("FAIL mid_release Q/cnt got %h/%0d expected d2/1", Q, cnt); end
    $display("test_reset_mid: Q=%h cnt=%0d done=%b", Q, cnt, done);
  endtask

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  task automatic test_rotate();
    logic [7:0] q_exp;
    rot = 1'b0; mode = 2'b11; D = 8'h01;
    step();
    q_exp = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      mode = 2'b10; rot = 1'b1; SIL = 1'b0;
      step();
      q_exp = {q_exp[6:0], q_exp[7]};
      checks++;
      if (Q !== q_exp) begin errors++; $display("FAIL rotl_q[%0d] got %h expected %h", k, Q, q_exp); end
      $display("test_rotate: edge %0d Q=%h cnt=%0d done=%b", k, Q, cnt, done);
    end
    checks++;
    if (Q !== 8'h01 || done !== 1'b1 || cnt !== 4'd8) begin
      errors++; $display("FAIL rotl_final Q/cnt/done got %h/%0d/%b expected 01/8/1", Q, cnt, done);
    end
    mode = 2'b01; SIR = 1'b0;
    step();
    checks++;
    if (Q !== 8'h80) begin errors++; $display("FAIL rotr_q got %h expected 80", Q); end
    rot = 1'b0;
  endtask
`endif

  initial begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    rot = 1'b0;
`endif
    test_reset();
    test_shift_right();
    test_shift_left_sat();
    test_hold_reload();
    test_reset_mid();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    test_rotate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
